// File: rtl/node_writeback.sv
// Node writeback engine: latches a burst of NUM_NODES 16-bit node values and
// streams them to consecutive data-memory addresses. Optional ReLU: NODE_WB_RELU_EN.
module node_writeback #(
    parameter int NUM_NODES = 16,
    parameter int ADDR_BITS = 11
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic                    iStart,
    input  logic [15:0]             iNodeAddr,
    input  logic [NUM_NODES*16-1:0] iNodes,
    output logic                    oReady,
    output logic                    oDataWrite,
    output logic [15:0]             oDataAddr,
    output logic [15:0]             oData,
    output logic                    oBusy,
    output logic                    oDone
);

    localparam int               IDX_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NODES - 1);
    localparam logic [15:0]      ADDR_MASK = 16'((32'd1 << ADDR_BITS) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [15:0]       r_base;
    logic [15:0]       r_nodes    [NUM_NODES];
    logic [15:0]       w_nodes_in [NUM_NODES];

    logic              w_accept;
    logic              w_write;
    logic [15:0]       w_node_cur;
    logic [15:0]       w_addr;
    logic [15:0]       w_data;

    generate
        for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_unpack
            assign w_nodes_in[gi] = iNodes[gi*16 +: 16];
        end
    endgenerate

    assign w_accept = (r_state == S_IDLE) && iStart;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (iStart) begin
                    w_state_next = S_WRITE;
                    w_idx_next   = '0;
                end
            end
            S_WRITE: begin
                w_idx_next = r_idx + IDX_W'(1);
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_DONE;
                    w_idx_next   = '0;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_base  <= '0;
            for (int k = 0; k < NUM_NODES; k++) begin
                r_nodes[k] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            if (w_accept) begin
                r_base <= iNodeAddr;
                for (int k = 0; k < NUM_NODES; k++) begin
                    r_nodes[k] <= w_nodes_in[k];
                end
            end
        end
    end

    // Masking the full sum equals adding in the low ADDR_BITS only, so the
    // address wraps naturally and the upper bits stay zero.
    assign w_node_cur = r_nodes[r_idx];
    assign w_addr     = (r_base + 16'(r_idx)) & ADDR_MASK;

`ifdef NODE_WB_RELU_EN
    assign w_data = w_node_cur[15] ? 16'h0000 : w_node_cur;
`else
    assign w_data = w_node_cur;
`endif

    // Reset gates the outputs combinationally so an aborted burst stops writing at once.
    assign w_write    = (r_state == S_WRITE) && !irst;
    assign oDataWrite = w_write;
    assign oDataAddr  = w_write ? w_addr : 16'h0000;
    assign oData      = w_write ? w_data : 16'h0000;
    assign oReady     = irst || (r_state == S_IDLE);
    assign oBusy      = !irst && ((r_state == S_WRITE) || (r_state == S_DONE));
    assign oDone      = !irst && (r_state == S_DONE);

endmodule

// File: tb/tb_node_writeback.sv
// Scoreboard bench for node_writeback: randomized and directed bursts checked
// against a cycle-level reference model of the burst protocol.
module tb_node_writeback;

    localparam int NN = 16;
    localparam int AB = 11;

    logic            iclk = 1'b0;
    logic            irst = 1'b1;
    logic            iStart = 1'b0;
    logic [15:0]     iNodeAddr = '0;
    logic [NN*16-1:0] iNodes = '0;
    logic            oReady, oDataWrite, oBusy, oDone;
    logic [15:0]     oDataAddr, oData;

    node_writeback #(.NUM_NODES(NN), .ADDR_BITS(AB)) dut (
        .iclk(iclk), .irst(irst), .iStart(iStart), .iNodeAddr(iNodeAddr),
        .iNodes(iNodes), .oReady(oReady), .oDataWrite(oDataWrite),
        .oDataAddr(oDataAddr), .oData(oData), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t  wr_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   wr_count = 0;
    int   ready_cycle = 0;
    bit   started = 0;
    logic exp_ready = 1'b1;
    logic exp_busy = 1'b0;

    always @(posedge iclk) cyc <= cyc + 1;

    function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef NODE_WB_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    // One clock cycle of stimulus; the model decides acceptance from its own timeline.
    task automatic drive(input logic rst, input logic start, input logic [15:0] addr,
                         input logic [NN*16-1:0] nodes);
        int c;
        irst = rst; iStart = start; iNodeAddr = addr; iNodes = nodes;
        c = cyc;
        exp_ready = rst || (c >= ready_cycle);
        exp_busy  = !rst && (c < ready_cycle);
        if (rst) begin
            while (wr_q.size() > 0 && wr_q[$].cyc >= c) void'(wr_q.pop_back());
            while (done_q.size() > 0 && done_q[$] >= c) void'(done_q.pop_back());
            ready_cycle = c + 1;
        end else if (start && c >= ready_cycle) begin
            for (int k = 0; k < NN; k++) begin
                wr_t e;
                e.cyc  = c + 1 + k;
                e.addr = 16'((int'(addr) + k) % (1 << AB));
                e.data = relu(nodes[k*16 +: 16]);
                wr_q.push_back(e);
            end
            done_q.push_back(c + NN + 1);
            ready_cycle = c + NN + 2;
        end
        started = 1;
        @(posedge iclk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, '0);
    endtask

    function automatic logic [NN*16-1:0] ramp(input logic [15:0] b);
        logic [NN*16-1:0] v;
        for (int k = 0; k < NN; k++) v[k*16 +: 16] = b + 16'(k);
        return v;
    endfunction

    function automatic logic [NN*16-1:0] rnd_nodes();
        logic [NN*16-1:0] v;
        for (int k = 0; k < NN; k++) v[k*16 +: 16] = 16'($urandom);
        return v;
    endfunction

    // Monitor: compares every cycle's outputs against the scoreboard.
    always @(negedge iclk) begin
        if (started) begin
            checks++;
            if (oReady !== exp_ready) begin
                failures++;
                $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, oReady, exp_ready);
            end
            checks++;
            if (oBusy !== exp_busy) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, oBusy, exp_busy);
            end
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL write_missing cyc=%0d got=none exp_addr=%h", wr_q[0].cyc, wr_q[0].addr);
                void'(wr_q.pop_front());
            end
            if (oDataWrite === 1'b1) begin
                wr_count++;
                checks++;
                if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
                    failures++;
                    $display("FAIL write_unexpected cyc=%0d got_addr=%h got_data=%h exp=no_write", cyc, oDataAddr, oData);
                end else begin
                    checks++;
                    if (oDataAddr !== wr_q[0].addr || oData !== wr_q[0].data) begin
                        failures++;
                        $display("FAIL write_value cyc=%0d got=%h/%h exp=%h/%h", cyc, oDataAddr, oData, wr_q[0].addr, wr_q[0].data);
                    end
                    void'(wr_q.pop_front());
                end
            end else begin
                checks++;
                if (oDataWrite !== 1'b0 || oDataAddr !== 16'h0 || oData !== 16'h0) begin
                    failures++;
                    $display("FAIL idle_outputs cyc=%0d got=%b/%h/%h exp=0/0000/0000", cyc, oDataWrite, oDataAddr, oData);
                end
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                checks++; failures++;
                $display("FAIL done_missing cyc=%0d got=none exp=pulse", done_q[0]);
                void'(done_q.pop_front());
            end
            checks++;
            if (oDone === 1'b1) begin
                if (done_q.size() == 0 || done_q[0] != cyc) begin
                    failures++;
                    $display("FAIL done_unexpected cyc=%0d got=1 exp=0", cyc);
                end else begin
                    void'(done_q.pop_front());
                end
            end else if (oDone !== 1'b0) begin
                failures++;
                $display("FAIL done_x cyc=%0d got=%b exp=0", cyc, oDone);
            end
        end
    end

    initial begin
        int wc0;
        @(posedge iclk); #1;
        drive(1'b1, 1'b0, 16'h0, '0);
        drive(1'b1, 1'b0, 16'h0, '0);
        idle(3);

        // basic burst
        drive(1'b0, 1'b1, 16'h0100, ramp(16'h1000));
        idle(NN + 3);
        // wrap-around
        drive(1'b0, 1'b1, 16'h07F8, rnd_nodes());
        idle(NN + 3);
        // ReLU corner values
        begin
            logic [NN*16-1:0] v;
            v = ramp(16'h0050);
            v[15:0]  = 16'hFFFF;
            v[31:16] = 16'h7FFF;
            v[47:32] = 16'h8000;
            drive(1'b0, 1'b1, 16'h0020, v);
        end
        idle(NN + 3);
        // request held high throughout a burst with different data
        drive(1'b0, 1'b1, 16'h0300, ramp(16'hA000));
        for (int i = 0; i < NN + 2; i++) drive(1'b0, 1'b1, 16'h0400, ramp(16'hB000));
        idle(NN + 3);
        // reset on the 5th write cycle
        wc0 = wr_count;
        drive(1'b0, 1'b1, 16'h0500, ramp(16'hC000));
        idle(4);
        drive(1'b1, 1'b0, 16'h0, '0);
        idle(3);
        checks++;
        if (wr_count - wc0 != 4) begin
            failures++;
            $display("FAIL reset_abort_writes got=%0d exp=4", wr_count - wc0);
        end
        // reset and request together
        drive(1'b1, 1'b1, 16'h0600, ramp(16'hD000));
        idle(4);
        // randomized traffic with occasional resets and changing inputs
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                  16'($urandom), rnd_nodes());
        end
        idle(2 * NN + 4);
        checks++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d/%0d exp=0/0", wr_q.size(), done_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
